// File: rtl/pwm_deadtime_gen.sv
// Complementary gate-drive generator with a dead band between high and low side.
// Optional fault latch enabled by defining PWM_DEADTIME_FAULT_EN.
module pwm_deadtime_gen #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dead_time,
`ifdef PWM_DEADTIME_FAULT_EN
  input  logic            fault,
  input  logic            fault_clr,
  output logic            fault_flag,
`endif
  output logic            pwm_hi,
  output logic            pwm_lo,
  output logic            dead_active
);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    LO_ON    = 3'd1,
    DT_TO_HI = 3'd2,
    HI_ON    = 3'd3,
    DT_TO_LO = 3'd4
`ifdef PWM_DEADTIME_FAULT_EN
    ,FAULT   = 3'd5
`endif
  } state_t;

  state_t          state, state_next;
  logic [DT_W-1:0] cnt, cnt_next;
  logic            hi_next, lo_next, dead_next;
`ifdef PWM_DEADTIME_FAULT_EN
  logic            flag_next;
`endif

  // State, counter and output registers. Outputs are decoded from the next
  // state so they change on the same edge as the state and never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= OFF;
      cnt         <= '0;
      pwm_hi      <= 1'b0;
      pwm_lo      <= 1'b0;
      dead_active <= 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
      fault_flag  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state       <= state_next;
      cnt         <= cnt_next;
      pwm_hi      <= hi_next;
      pwm_lo      <= lo_next;
      dead_active <= dead_next;
`ifdef PWM_DEADTIME_FAULT_EN
      fault_flag  <= flag_next;
`endif
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    state_next = state;
    cnt_next   = cnt;
`ifdef PWM_DEADTIME_FAULT_EN
    if (fault) begin
      state_next = FAULT;
      cnt_next   = '0;
    end else if (state == FAULT) begin
      if (fault_clr) state_next = OFF;
    end else
`endif
    if (!enable) begin
      state_next = OFF;
      cnt_next   = '0;
    end else begin
      unique case (state)
        OFF: begin
          state_next = pwm_in ? DT_TO_HI : DT_TO_LO;
          cnt_next   = dead_time;
        end
        LO_ON: if (pwm_in) begin
          state_next = DT_TO_HI;
          cnt_next   = dead_time;
        end
        HI_ON: if (!pwm_in) begin
          state_next = DT_TO_LO;
          cnt_next   = dead_time;
        end
        // A reversal mid-band restarts a full band toward the other side.
        DT_TO_HI: begin
          if (!pwm_in) begin
            state_next = DT_TO_LO;
            cnt_next   = dead_time;
          end else if (cnt == '0) begin
            state_next = HI_ON;
          end else begin
            cnt_next = cnt - DT_W'(1);
          end
        end
        DT_TO_LO: begin
          if (pwm_in) begin
            state_next = DT_TO_HI;
            cnt_next   = dead_time;
          end else if (cnt == '0) begin
            state_next = LO_ON;
          end else begin
            cnt_next = cnt - DT_W'(1);
          end
        end
        default: begin
          state_next = OFF;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    hi_next   = (state_next == HI_ON);
    lo_next   = (state_next == LO_ON);
    dead_next = (state_next == DT_TO_HI) || (state_next == DT_TO_LO);
`ifdef PWM_DEADTIME_FAULT_EN
    flag_next = (state_next == FAULT);
`endif
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: dead-band lengths, aborts, enable and reset.
// Fault sequence runs only when PWM_DEADTIME_FAULT_EN is defined.
module tb_pwm_deadtime_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       pwm_in;
  logic [7:0] dead_time;
  logic       pwm_hi, pwm_lo, dead_active;
`ifdef PWM_DEADTIME_FAULT_EN
  logic       fault, fault_clr, fault_flag;
`endif

  int vectors    = 0;
  int miscompares = 0;

  pwm_deadtime_gen #(.DT_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .pwm_in      (pwm_in),
    .dead_time   (dead_time),
`ifdef PWM_DEADTIME_FAULT_EN
    .fault       (fault),
    .fault_clr   (fault_clr),
    .fault_flag  (fault_flag),
`endif
    .pwm_hi      (pwm_hi),
    .pwm_lo      (pwm_lo),
    .dead_active (dead_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic hi, input logic lo, input logic da);
    check({tag, ".hi"}, {31'd0, pwm_hi}, {31'd0, hi});
    check({tag, ".lo"}, {31'd0, pwm_lo}, {31'd0, lo});
    check({tag, ".da"}, {31'd0, dead_active}, {31'd0, da});
  endtask

  // Advance one edge, then check the two sides are never on together.
  task automatic step();
    @(posedge clk);
    #1;
    check("overlap", {31'd0, pwm_hi & pwm_lo}, 32'd0);
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    enable    = 1'b1;
    pwm_in    = 1'b0;
    dead_time = 8'd3;
`ifdef PWM_DEADTIME_FAULT_EN
    fault     = 1'b0;
    fault_clr = 1'b0;
`endif
    #12;
    expect_out("reset", 1'b0, 1'b0, 1'b0);

    // Power-up into low side: 4 dead cycles, then pwm_lo.
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) begin
      step();
      expect_out("pwrup_dead", 1'b0, 1'b0, 1'b1);
    end
    step();
    expect_out("pwrup_lo", 1'b0, 1'b1, 1'b0);
    repeat (2) begin
      step();
      expect_out("lo_steady", 1'b0, 1'b1, 1'b0);
    end

    // Low to high with dead_time=3; a mid-band dead_time change is ignored.
    pwm_in = 1'b1;
    step();
    expect_out("lo_fall", 1'b0, 1'b0, 1'b1);
    dead_time = 8'd7;
    repeat (3) begin
      step();
      expect_out("to_hi_dead", 1'b0, 1'b0, 1'b1);
    end
    step();
    expect_out("hi_on", 1'b1, 1'b0, 1'b0);
    step();
    expect_out("hi_hold", 1'b1, 1'b0, 1'b0);

    // dead_time=0, toggle every 8 cycles: 1-cycle gap at each edge.
    dead_time = 8'd0;
    for (int i = 0; i < 5; i++) begin
      pwm_in = i[0];
      step();
      expect_out("dt0_gap", 1'b0, 1'b0, 1'b1);
      repeat (7) begin
        step();
        expect_out("dt0_on", i[0], ~i[0], 1'b0);
      end
    end

    // Short 3-cycle high pulse with dead_time=5 is swallowed.
    dead_time = 8'd5;
    pwm_in = 1'b1;
    repeat (3) begin
      step();
      expect_out("short_hi", 1'b0, 1'b0, 1'b1);
    end
    pwm_in = 1'b0;
    repeat (6) begin
      step();
      expect_out("short_back", 1'b0, 1'b0, 1'b1);
    end
    step();
    expect_out("short_lo", 1'b0, 1'b1, 1'b0);

    // Maximum dead_time: 256 dead cycles, no wrap.
    dead_time = 8'd255;
    pwm_in = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!pwm_hi && n < 400);
    check("max_gap", n - 1, 32'd256);

    // Enable drop while HI_ON, with pwm_in still high.
    enable = 1'b0;
    step();
    expect_out("en_off", 1'b0, 1'b0, 1'b0);
    step();
    expect_out("en_off_hold", 1'b0, 1'b0, 1'b0);

    // Reset pulse mid DT_TO_HI, then restart from OFF.
    dead_time = 8'd2;
    enable = 1'b1;
    step();
    expect_out("re_dead", 1'b0, 1'b0, 1'b1);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    expect_out("rst_async", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expect_out("rst_hold", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (3) begin
      step();
      expect_out("restart_dead", 1'b0, 1'b0, 1'b1);
    end
    step();
    expect_out("restart_hi", 1'b1, 1'b0, 1'b0);

`ifdef PWM_DEADTIME_FAULT_EN
    fault = 1'b1;
    step();
    expect_out("fault", 1'b0, 1'b0, 1'b0);
    check("fault_flag", {31'd0, fault_flag}, 32'd1);
    fault = 1'b0;
    step();
    check("fault_latched", {31'd0, fault_flag}, 32'd1);
    fault = 1'b1;
    fault_clr = 1'b1;
    step();
    check("fault_clr_blocked", {31'd0, fault_flag}, 32'd1);
    fault = 1'b0;
    step();
    check("fault_cleared", {31'd0, fault_flag}, 32'd0);
    expect_out("fault_off", 1'b0, 1'b0, 1'b0);
    fault_clr = 1'b0;
    step();
    expect_out("fault_resume", 1'b0, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_gen.md
PWM_DEADTIME_GEN -- requirements
Module: pwm_deadtime_gen

Interface
REQ-001 SHALL have parameter DT_W, default 8, width of dead_time and the internal dead-band counter.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset, asynchronous assert, active-low.
REQ-004 SHALL have port enable, input, 1, 1 = drive outputs from pwm_in; 0 = both outputs forced low.
REQ-005 SHALL have port pwm_in, input, 1, PWM from the upstream pwm_generator, synchronous to clk.
REQ-006 SHALL have port dead_time, input, DT_W, dead-band length control, sampled at each dead-band entry.
REQ-007 SHALL have port pwm_hi, output, 1, registered high-side gate drive.
REQ-008 SHALL have port pwm_lo, output, 1, registered low-side gate drive.
REQ-009 SHALL have port dead_active, output, 1, registered; 1 while in either dead-band state.

Function
REQ-010 SHALL implement states OFF, LO_ON, DT_TO_HI, HI_ON, DT_TO_LO; outputs are a registered decode of the state: HI_ON -> pwm_hi=1; LO_ON -> pwm_lo=1; otherwise both 0.
REQ-011 SHALL never assert pwm_hi and pwm_lo in the same cycle, under any input sequence.
REQ-012 OFF, enable=1: next edge -> DT_TO_HI if pwm_in=1, else DT_TO_LO; counter loaded with dead_time.
REQ-013 LO_ON, pwm_in=1: next edge -> DT_TO_HI, counter <= dead_time; HI_ON, pwm_in=0: next edge -> DT_TO_LO, counter <= dead_time.
REQ-014 In DT_TO_HI/DT_TO_LO, counter SHALL decrement by 1 per cycle while nonzero; when counter==0, next edge -> HI_ON/LO_ON respectively.
REQ-015 Both-low interval SHALL therefore be exactly dead_time+1 cycles; dead_time=0 gives 1 cycle; dead_time=2^DT_W-1 gives 2^DT_W cycles; counter SHALL never wrap below 0.
REQ-016 pwm_in reverting during DT_TO_HI SHALL abort to DT_TO_LO with counter reloaded from dead_time (and symmetrically DT_TO_LO -> DT_TO_HI); the target side is not asserted until a full dead band completes.
REQ-017 pwm_in pulses shorter than dead_time+1 cycles SHALL be swallowed (target output never asserts).
REQ-018 enable=0 in any state SHALL force next-edge transition to OFF; enable has priority over pwm_in.
REQ-019 dead_time changes mid-dead-band SHALL NOT affect the current countdown.
REQ-020 Latency: pwm_lo falls 1 cycle after pwm_in rise is sampled in LO_ON; pwm_hi rises dead_time+1 cycles after pwm_lo falls.

Reset
REQ-021 reset_n=0 SHALL immediately force state OFF, counter 0, pwm_hi=0, pwm_lo=0, dead_active=0 (and fault_flag=0 when compiled in).
REQ-022 Reset mid-dead-band or mid-on-phase SHALL discard the countdown; after release, operation resumes via REQ-012.

Configuration
REQ-023 Macro PWM_DEADTIME_FAULT_EN, when defined, SHALL add input fault (1 bit), input fault_clr (1 bit), output fault_flag (1 bit) and state FAULT.
REQ-024 With PWM_DEADTIME_FAULT_EN: fault=1 in any state -> next edge FAULT, both outputs 0, fault_flag=1; fault has priority over enable and pwm_in.
REQ-025 With PWM_DEADTIME_FAULT_EN: FAULT exits to OFF only on a cycle with fault_clr=1 and fault=0; fault_flag clears on the same edge.
REQ-026 Without PWM_DEADTIME_FAULT_EN: fault ports, fault_flag and FAULT state SHALL not exist; behaviour is REQ-010..REQ-022 only.

Verification
REQ-027 Reset, enable=1, pwm_in=0, dead_time=3 -> pwm_lo rises 4 cycles after reset release; pwm_hi stays 0.
REQ-028 Steady LO_ON, dead_time=3, pwm_in rises -> pwm_lo falls next edge, both low exactly 4 cycles, then pwm_hi=1, dead_active=1 during the gap only.
REQ-029 dead_time=0, pwm_in toggling every 8 cycles -> both-low gap of exactly 1 cycle at each edge; overlap checker never fires.
REQ-030 dead_time=5, pwm_in 1-high pulse of 3 cycles from LO_ON -> pwm_hi never asserts; pwm_lo returns after 6-cycle gap.
REQ-031 enable dropped while HI_ON -> both outputs 0 next edge; reset_n pulsed mid DT_TO_HI -> outputs 0 immediately, restart per REQ-012.
REQ-032 With PWM_DEADTIME_FAULT_EN: fault pulse during HI_ON -> both 0, fault_flag=1 next edge; held until fault_clr with fault=0, then OFF.
